div_ctrl: RTL and testbench

- Multi-cycle sequencer and datapath for the RV32M divide group: DIV, DIVU, REM, REMU.
- The decoder issues these with register write disabled. This block runs a 32-iteration restoring division and then presents the result with its destination register address.
- Sits beside the execute stage. Execute holds the pipeline while busy_o is high and performs the register write on ready_o.

---
 rtl/div_ctrl_if.sv | 27 ++
 rtl/div_ctrl.sv | 142 ++++++++++++++
 tb/tb_div_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/div_ctrl_if.sv
// Execute-stage <-> divide sequencer handshake and operand bundle.
interface div_ctrl_if #(
    parameter int unsigned XLEN = 32
);
    logic            start_i;
    logic [2:0]      op_i;
    logic [XLEN-1:0] dividend_i;
    logic [XLEN-1:0] divisor_i;
    logic [4:0]      reg_waddr_i;
    logic            abort_i;
    logic            busy_o;
    logic            ready_o;
    logic [XLEN-1:0] result_o;
    logic [4:0]      reg_waddr_o;

    // Execute stage side
    modport master (
        output start_i, op_i, dividend_i, divisor_i, reg_waddr_i, abort_i,
        input  busy_o, ready_o, result_o, reg_waddr_o
    );

    // Divider side
    modport slave (
        input  start_i, op_i, dividend_i, divisor_i, reg_waddr_i, abort_i,
        output busy_o, ready_o, result_o, reg_waddr_o
    );
endinterface

// File: rtl/div_ctrl.sv
// RV32M divide group (DIV/DIVU/REM/REMU): 32-step restoring divider on
// magnitudes, with sign fix-up applied when the result is registered.
module div_ctrl #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ITER_W = 6
) (
    input  logic       clk,
    input  logic       rst,
    div_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_END
    } state_t;

    state_t            state, state_nxt;
    logic              load, step, fin;

    logic [ITER_W-1:0] cnt;
    logic [XLEN-1:0]   rem, quot, dvsr;
    logic              sel_rem, q_neg, r_neg;
    logic [4:0]        rd_q;
    logic [XLEN-1:0]   result_q;
    logic [4:0]        waddr_q;
    logic              ready_q;

    logic              is_signed, a_neg, b_neg, div_zero;
    logic [XLEN-1:0]   a_abs, b_abs;
    logic [XLEN:0]     shifted, diff;
    logic [XLEN-1:0]   sel_val, fin_val;
    logic              sel_neg;

    // Operand conditioning at start: magnitudes only for signed ops
    always_comb begin
        is_signed = ~bus.op_i[0];
        a_neg     = is_signed & bus.dividend_i[XLEN-1];
        b_neg     = is_signed & bus.divisor_i[XLEN-1];
        a_abs     = a_neg ? -bus.dividend_i : bus.dividend_i;
        b_abs     = b_neg ? -bus.divisor_i  : bus.divisor_i;
        div_zero  = (bus.divisor_i == '0);
    end

    // One restoring step on the 33-bit partial remainder, plus result select
    always_comb begin
        shifted = {rem, quot[XLEN-1]};
        diff    = shifted - {1'b0, dvsr};
        sel_val = sel_rem ? rem   : quot;
        sel_neg = sel_rem ? r_neg : q_neg;
        fin_val = sel_neg ? -sel_val : sel_val;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Next-state and datapath control; abort wins in every busy state
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        fin       = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start_i && !bus.abort_i && bus.op_i[2]) begin
                    load      = 1'b1;
                    state_nxt = div_zero ? S_END : S_CALC;
                end
            end
            S_CALC: begin
                if (bus.abort_i) begin
                    state_nxt = S_IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt == ITER_W'(XLEN - 1)) state_nxt = S_END;
                end
            end
            S_END: begin
                state_nxt = S_IDLE;
                fin       = ~bus.abort_i;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath registers. A zero divisor preloads the architectural answer
    // (quotient all ones, remainder = |dividend|) and suppresses quotient
    // negation; the remainder sign fix-up then restores the raw dividend.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            rem      <= '0;
            quot     <= '0;
            dvsr     <= '0;
            sel_rem  <= 1'b0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            rd_q     <= '0;
            result_q <= '0;
            waddr_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            ready_q <= fin;
            if (load) begin
                cnt     <= '0;
                dvsr    <= b_abs;
                sel_rem <= bus.op_i[1];
                rd_q    <= bus.reg_waddr_i;
                r_neg   <= a_neg;
                if (div_zero) begin
                    rem   <= a_abs;
                    quot  <= '1;
                    q_neg <= 1'b0;
                end else begin
                    rem   <= '0;
                    quot  <= a_abs;
                    q_neg <= a_neg ^ b_neg;
                end
            end else if (step) begin
                cnt <= cnt + 1'b1;
                if (!diff[XLEN]) begin
                    rem  <= diff[XLEN-1:0];
                    quot <= {quot[XLEN-2:0], 1'b1};
                end else begin
                    rem  <= shifted[XLEN-1:0];
                    quot <= {quot[XLEN-2:0], 1'b0};
                end
            end
            if (fin) begin
                result_q <= fin_val;
                waddr_q  <= rd_q;
            end
        end
    end

    assign bus.busy_o      = (state != S_IDLE);
    assign bus.ready_o     = ready_q;
    assign bus.result_o    = result_q;
    assign bus.reg_waddr_o = waddr_q;
endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed cases plus random operands
// compared against an arithmetic RV32M reference.
module tb_div_ctrl;
    localparam logic [2:0] OP_DIV  = 3'b100;
    localparam logic [2:0] OP_DIVU = 3'b101;
    localparam logic [2:0] OP_REM  = 3'b110;
    localparam logic [2:0] OP_REMU = 3'b111;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;
    logic [31:0] last_result;
    logic [4:0]  last_waddr;

    div_ctrl_if #(.XLEN(32)) bus ();

    div_ctrl #(.XLEN(32), .ITER_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RV32M semantics from plain arithmetic
    function automatic logic [31:0] ref_div(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : a;
            return op[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return op[1] ? (a % b) : (a / b);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the ready cycle.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd);
        logic [31:0] exp;
        int unsigned exp_lat, idx, nbusy;
        exp     = ref_div(op, a, b);
        exp_lat = (b == 32'd0) ? 1 : 33;
        bus.op_i        = op;
        bus.dividend_i  = a;
        bus.divisor_i   = b;
        bus.reg_waddr_i = rd;
        bus.start_i     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start_i = 1'b0;
        chk("ready_low_after_start", {31'd0, bus.ready_o}, 32'd0);
        idx   = 0;
        nbusy = 0;
        while (bus.ready_o !== 1'b1 && idx < 40) begin
            if (bus.busy_o === 1'b1) nbusy++;
            @(negedge clk);
            idx++;
        end
        chk("latency", idx, exp_lat);
        chk("busy_cycles", nbusy, exp_lat);
        chk("busy_low_in_ready", {31'd0, bus.busy_o}, 32'd0);
        chk("result", bus.result_o, exp);
        chk("waddr", {27'd0, bus.reg_waddr_o}, {27'd0, rd});
        last_result = exp;
        last_waddr  = rd;
    endtask

    task automatic idle_check();
        @(negedge clk);
        chk("ready_one_cycle", {31'd0, bus.ready_o}, 32'd0);
        chk("result_hold", bus.result_o, last_result);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        int unsigned sel;

        n_assert = 0;
        n_fail   = 0;
        last_result = '0;
        last_waddr  = '0;
        rst = 1'b0;
        bus.start_i = 1'b0; bus.abort_i = 1'b0; bus.op_i = '0;
        bus.dividend_i = '0; bus.divisor_i = '0; bus.reg_waddr_i = '0;
        #3;
        chk("rst_busy",   {31'd0, bus.busy_o},  32'd0);
        chk("rst_ready",  {31'd0, bus.ready_o}, 32'd0);
        chk("rst_result", bus.result_o, 32'd0);
        chk("rst_waddr",  {27'd0, bus.reg_waddr_o}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Directed arithmetic cases
        run_op(OP_DIVU, 32'd100, 32'd7, 5'd5);                   idle_check();
        run_op(OP_REMU, 32'd100, 32'd7, 5'd6);                   idle_check();
        run_op(OP_DIV,  32'hFFFF_FFF9, 32'd2, 5'd7);             idle_check();
        run_op(OP_REM,  32'hFFFF_FFF9, 32'd2, 5'd8);             idle_check();
        run_op(OP_DIV,  32'd7, 32'hFFFF_FFFE, 5'd9);             idle_check();
        run_op(OP_DIV,  32'h1234_5678, 32'd0, 5'd10);            idle_check();
        run_op(OP_REMU, 32'h1234_5678, 32'd0, 5'd11);            idle_check();
        run_op(OP_REM,  32'h8765_4321, 32'd0, 5'd12);            idle_check();
        run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd13);    idle_check();
        run_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd14);    idle_check();
        run_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15);    idle_check();

        // Non-divide funct3 and start with abort are not accepted
        bus.op_i = 3'b000; bus.dividend_i = 32'd10; bus.divisor_i = 32'd2;
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        chk("non_div_ignored", {31'd0, bus.busy_o}, 32'd0);
        bus.op_i = OP_DIVU; bus.start_i = 1'b1; bus.abort_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0; bus.abort_i = 1'b0;
        chk("start_with_abort", {31'd0, bus.busy_o}, 32'd0);

        // Abort mid-calculation, with an ignored start while busy
        bus.op_i = OP_DIVU; bus.dividend_i = 32'd50; bus.divisor_i = 32'd5;
        bus.reg_waddr_i = 5'd20; bus.start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (5) @(negedge clk);
        bus.dividend_i = 32'd9; bus.divisor_i = 32'd3; bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        chk("busy_after_ignored_start", {31'd0, bus.busy_o}, 32'd1);
        repeat (4) @(negedge clk);
        bus.abort_i = 1'b1;
        @(negedge clk);
        bus.abort_i = 1'b0;
        chk("abort_busy",   {31'd0, bus.busy_o},  32'd0);
        chk("abort_ready",  {31'd0, bus.ready_o}, 32'd0);
        chk("abort_result", bus.result_o, last_result);
        @(negedge clk);
        chk("abort_no_late_ready", {31'd0, bus.ready_o}, 32'd0);

        // Fresh op after abort, then back-to-back start in the ready cycle
        run_op(OP_DIVU, 32'd9, 32'd3, 5'd21);
        run_op(OP_DIV,  32'hFFFF_FF00, 32'd16, 5'd22);           idle_check();

        // Abort landing on the final edge suppresses the result
        bus.op_i = OP_DIVU; bus.dividend_i = 32'd1000; bus.divisor_i = 32'd3;
        bus.reg_waddr_i = 5'd23; bus.start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (32) @(negedge clk);
        bus.abort_i = 1'b1;
        @(negedge clk);
        bus.abort_i = 1'b0;
        chk("abort_end_ready",  {31'd0, bus.ready_o}, 32'd0);
        chk("abort_end_busy",   {31'd0, bus.busy_o},  32'd0);
        chk("abort_end_result", bus.result_o, last_result);
        chk("abort_end_waddr",  {27'd0, bus.reg_waddr_o}, {27'd0, last_waddr});

        // Asynchronous reset in the middle of a calculation
        bus.op_i = OP_DIVU; bus.dividend_i = 32'hFFFF_FFFF; bus.divisor_i = 32'd3;
        bus.reg_waddr_i = 5'd24; bus.start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (20) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_busy",   {31'd0, bus.busy_o},  32'd0);
        chk("async_rst_ready",  {31'd0, bus.ready_o}, 32'd0);
        chk("async_rst_result", bus.result_o, 32'd0);
        chk("async_rst_waddr",  {27'd0, bus.reg_waddr_o}, 32'd0);
        last_result = '0;
        last_waddr  = '0;
        @(negedge clk);
        rst = 1'b1;
        repeat (14) @(negedge clk);
        chk("no_ready_after_rst", {31'd0, bus.ready_o}, 32'd0);
        run_op(OP_DIVU, 32'd81, 32'd9, 5'd25);                   idle_check();

        // Random operands against the reference
        for (int i = 0; i < 24; i++) begin
            op  = {1'b1, 2'($urandom_range(0, 3))};
            a   = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'($urandom_range(1, 15));
                3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                4: begin a = 32'($urandom_range(0, 1000)); b = $urandom; end
                default: b = $urandom;
            endcase
            run_op(op, a, b, 5'($urandom_range(0, 31)));
            idle_check();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
